// File: rtl/cache_pkg.sv
// Shared types and constants for the cache request arbiter slice.
// Address layout is tag | set | offset.
package cache_pkg;

  localparam int ADDR_W = 16;
  localparam int TAG_W  = 10;
  localparam int SET_W  = 4;
  localparam int OFF_W  = 2;
  localparam int CNT_W  = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first valid bit at or after the
// pointer (wrapping) wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW-1:0] w_k;

  // Walk offsets from far to near so the nearest hit is written last.
  always_comb begin
    w_k     = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = i_ptr + PW'(i);
      if (i_valid[w_k]) begin
        o_grant = N'(1) << w_k;
        o_idx   = w_k;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin front end sharing one cache controller between
// several requesters, with completion timeout and hit/miss counters.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cache_req_valid,
  output logic                      cache_req_rw,
  output logic [ADDR_W-1:0]         cache_req_addr,
  input  logic                      cache_req_ready,
  input  logic                      cache_done,
  input  logic                      cache_hit,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_hit,
  output logic                      rsp_err,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count,
  output logic                      busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_id;
  logic [TW-1:0]       r_timer;
  logic                r_cvalid;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [NUM_REQ-1:0]  r_rsp_v;
  logic                r_rsp_hit;
  logic                r_rsp_err;
  logic [CNT_W-1:0]    r_hit;
  logic [CNT_W-1:0]    r_miss;

  logic [NUM_REQ-1:0]  w_grant;
  logic [PW-1:0]       w_idx;
  logic                w_any;
  logic [NUM_REQ-1:0]  w_id_oh;
  logic                w_idle;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Gate with reset so ready is quiet while reset is held.
  assign w_idle    = (r_state == ST_IDLE) && reset;
  assign req_ready = w_idle ? w_grant : '0;
  assign w_id_oh   = NUM_REQ'(1) << r_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_timer   <= '0;
      r_cvalid  <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_rsp_v   <= '0;
      r_rsp_hit <= 1'b0;
      r_rsp_err <= 1'b0;
      r_hit     <= '0;
      r_miss    <= '0;
    end else begin
      r_rsp_v   <= '0;
      r_rsp_hit <= 1'b0;
      r_rsp_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id     <= w_idx;
            r_rw     <= req_rw[w_idx];
            r_addr   <= req_addr[w_idx*ADDR_W +: ADDR_W];
            r_cvalid <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cache_req_ready) begin
            r_cvalid <= 1'b0;
            r_timer  <= '0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cache_done) begin
            r_rsp_v   <= w_id_oh;
            r_rsp_hit <= cache_hit;
            if (cache_hit) r_hit <= sat_inc(r_hit);
            else           r_miss <= sat_inc(r_miss);
            r_ptr   <= r_id + PW'(1);
            r_state <= ST_IDLE;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_rsp_v   <= w_id_oh;
            r_rsp_err <= 1'b1;
            r_ptr     <= r_id + PW'(1);
            r_state   <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cache_req_valid = r_cvalid;
  assign cache_req_rw    = r_rw;
  assign cache_req_addr  = r_addr;
  assign rsp_valid       = r_rsp_v;
  assign rsp_hit         = r_rsp_hit;
  assign rsp_err         = r_rsp_err;
  assign hit_count       = r_hit;
  assign miss_count      = r_miss;
  assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: grant, fairness, backpressure,
// timeout, counter saturation and asynchronous reset.
module tb_cache_req_arbiter;
  import cache_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            cache_req_valid;
  logic            cache_req_rw;
  logic [AW-1:0]   cache_req_addr;
  logic            cache_req_ready;
  logic            cache_done;
  logic            cache_hit;
  logic [N-1:0]    rsp_valid;
  logic            rsp_hit;
  logic            rsp_err;
  logic [13:0]     hit_count;
  logic [13:0]     miss_count;
  logic            busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_req_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .TIMEOUT (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .cache_req_valid (cache_req_valid),
    .cache_req_rw    (cache_req_rw),
    .cache_req_addr  (cache_req_addr),
    .cache_req_ready (cache_req_ready),
    .cache_done      (cache_done),
    .cache_hit       (cache_hit),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_err         (rsp_err),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .busy            (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid       = '0;
    req_rw          = '0;
    req_addr        = '0;
    cache_req_ready = 1'b0;
    cache_done      = 1'b0;
    cache_hit       = 1'b0;
  endtask

  task automatic pulse_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errs++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    checks++;
    if (cache_req_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_busy: cvalid=%b busy=%b want 0 0",
               cache_req_valid, busy);
    end
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_rsp: got %b/%b want 0000/0", rsp_valid, rsp_err);
    end
    checks++;
    if (hit_count !== 14'd0 || miss_count !== 14'd0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    req_valid = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single;
    req_valid = 4'b0100;
    req_rw    = 4'b0000;
    req_addr  = '0;
    req_addr[2*AW +: AW] = 16'h0A5C;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errs++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (cache_req_valid !== 1'b1 || cache_req_addr !== 16'h0A5C ||
        cache_req_rw !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL single_issue: v=%b a=%h rw=%b busy=%b want 1 0a5c 0 1",
               cache_req_valid, cache_req_addr, cache_req_rw, busy);
    end
    cache_req_ready = 1'b1;
    tick();
    cache_req_ready = 1'b0;
    checks++;
    if (cache_req_valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL single_wait: v=%b busy=%b want 0 1",
               cache_req_valid, busy);
    end
    cache_done = 1'b1;
    cache_hit  = 1'b1;
    tick();
    cache_done = 1'b0;
    cache_hit  = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_hit !== 1'b1 || rsp_err !== 1'b0 ||
        hit_count !== 14'd1 || miss_count !== 14'd0) begin
      errs++;
      $display("FAIL single_rsp: v=%b h=%b e=%b hc=%0d mc=%0d want 0100 1 0 1 0",
               rsp_valid, rsp_hit, rsp_err, hit_count, miss_count);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_pulse: v=%b busy=%b want 0000 0", rsp_valid, busy);
    end
  endtask

  task automatic test_fairness;
    int order[$];
    int when[$];
    pulse_reset();
    req_valid       = 4'b1111;
    req_addr        = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    cache_req_ready = 1'b1;
    cache_done      = 1'b1;
    cache_hit       = 1'b1;
    #1;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      for (int b = 0; b < N; b++)
        if (req_ready[b]) begin
          order.push_back(b);
          when.push_back(c);
        end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    cache_req_ready = 1'b0;
    cache_done      = 1'b0;
    cache_hit       = 1'b0;
    checks++;
    if (order.size() != 5) begin
      errs++;
      $display("FAIL fair_count: got %0d grants want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != i % N) begin
          errs++;
          $display("FAIL fair_order%0d: got %0d want %0d", i, order[i], i % N);
        end
      end
      checks++;
      if (when[4] - when[0] != 12) begin
        errs++;
        $display("FAIL fair_rate: got %0d cycles want 12", when[4] - when[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    req_valid = 4'b0010;
    req_rw    = 4'b0010;
    req_addr  = '0;
    req_addr[1*AW +: AW] = 16'h1234;
    cache_req_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL bp_ready: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (5) begin
      if (cache_req_valid !== 1'b1 || cache_req_addr !== 16'h1234 ||
          cache_req_rw !== 1'b1 || busy !== 1'b1 || rsp_valid !== 4'b0000)
        bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL bp_stable: got %0d bad cycles want 0", bad);
    end
    cache_req_ready = 1'b1;
    tick();
    cache_req_ready = 1'b0;
    checks++;
    if (cache_req_valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL bp_accept: v=%b busy=%b want 0 1", cache_req_valid, busy);
    end
    cache_done = 1'b1;
    cache_hit  = 1'b0;
    tick();
    cache_done = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_hit !== 1'b0 || rsp_err !== 1'b0 ||
        miss_count !== 14'd1 || hit_count !== 14'd5) begin
      errs++;
      $display("FAIL bp_rsp: v=%b h=%b e=%b mc=%0d hc=%0d want 0010 0 0 1 5",
               rsp_valid, rsp_hit, rsp_err, miss_count, hit_count);
    end
  endtask

  task automatic test_timeout;
    int bad = 0;
    req_valid = 4'b1000;
    req_addr  = '0;
    req_addr[3*AW +: AW] = 16'hBEEF;
    cache_req_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errs++;
      $display("FAIL to_ready: got %b want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    cache_req_ready = 1'b0;
    repeat (63) begin
      tick();
      if (rsp_valid !== 4'b0000 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL to_early: got %0d early cycles want 0", bad);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_hit !== 1'b0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL to_rsp: v=%b e=%b h=%b busy=%b want 1000 1 0 0",
               rsp_valid, rsp_err, rsp_hit, busy);
    end
    checks++;
    if (miss_count !== 14'd1 || hit_count !== 14'd5) begin
      errs++;
      $display("FAIL to_cnt: got %0d/%0d want 5/1", hit_count, miss_count);
    end
    // Done arriving on the very last WAIT cycle must beat the timeout.
    req_valid = 4'b0001;
    cache_req_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL to_next_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    cache_req_ready = 1'b0;
    repeat (63) tick();
    cache_done = 1'b1;
    cache_hit  = 1'b1;
    tick();
    cache_done = 1'b0;
    cache_hit  = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_hit !== 1'b1 ||
        hit_count !== 14'd6) begin
      errs++;
      $display("FAIL to_done_wins: v=%b e=%b h=%b hc=%0d want 0001 0 1 6",
               rsp_valid, rsp_err, rsp_hit, hit_count);
    end
  endtask

  task automatic test_saturation;
    int n = 0;
    int cyc = 0;
    pulse_reset();
    req_valid       = 4'b0001;
    cache_req_ready = 1'b1;
    cache_done      = 1'b1;
    cache_hit       = 1'b0;
    while (n < 16383 && cyc < 60000) begin
      tick();
      cyc++;
      if (rsp_valid !== 4'b0000) n++;
    end
    checks++;
    if (n != 16383 || miss_count !== 14'h3FFF) begin
      errs++;
      $display("FAIL sat_fill: n=%0d mc=%h want 16383 3fff", n, miss_count);
    end
    while (n < 16384 && cyc < 60100) begin
      tick();
      cyc++;
      if (rsp_valid !== 4'b0000) n++;
    end
    checks++;
    if (n != 16384 || miss_count !== 14'h3FFF || hit_count !== 14'd0) begin
      errs++;
      $display("FAIL sat_hold: n=%0d mc=%h hc=%0d want 16384 3fff 0",
               n, miss_count, hit_count);
    end
    req_valid = '0;
    repeat (3) tick();
    idle_inputs();
  endtask

  task automatic test_async_reset;
    req_valid       = 4'b0100;
    cache_req_ready = 1'b1;
    #1;
    tick();
    req_valid = '0;
    tick();
    cache_req_ready = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL ar_pre: busy=%b want 1", busy);
    end
    #2;
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (busy !== 1'b0 || cache_req_valid !== 1'b0 || req_ready !== 4'b0000 ||
        miss_count !== 14'd0 || rsp_valid !== 4'b0000) begin
      errs++;
      $display("FAIL ar_now: busy=%b cv=%b rdy=%b mc=%h rv=%b want 0 0 0000 0 0000",
               busy, cache_req_valid, req_ready, miss_count, rsp_valid);
    end
    cache_done = 1'b1;
    cache_hit  = 1'b1;
    repeat (2) tick();
    checks++;
    if (rsp_valid !== 4'b0000 || hit_count !== 14'd0) begin
      errs++;
      $display("FAIL ar_norsp: rv=%b hc=%0d want 0000 0", rsp_valid, hit_count);
    end
    cache_done = 1'b0;
    cache_hit  = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL ar_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
